tdm_demux_1x16: RTL

- Receiving end of the 16-channel time-division link: takes one WIDTH-bit sample per accepted slot from a serial TDM stream and distributes it to 16 per-channel output registers.
- Keeps a slot counter locked to a start-of-frame marker.
- Also provides a frame-coherent double-buffered snapshot of all 16 channels, updated once per complete frame.
- Sits downstream of the 16:1 channel multiplexer and restores parallel channel data.

---
 rtl/tdm_demux_1x16.sv | 74 +++++++
 1 files changed

// File: rtl/tdm_demux_1x16.sv
// tdm_demux_1x16: receiving end of a 16-slot TDM link.
// A slot counter is locked to the start-of-frame marker. Each accepted
// sample is steered into its per-channel register, and every complete
// frame is published as one coherent 16-channel snapshot.
module tdm_demux_1x16 #(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic [16*WIDTH-1:0] out,
  output logic [15:0]         out_valid,
  output logic [16*WIDTH-1:0] frame_out,
  output logic                frame_valid,
  output logic [3:0]          slot,
  output logic                locked,
  output logic                sync_err
);

  localparam int unsigned NCH      = 16;
  localparam int unsigned SLOT_W   = 4;
  localparam int unsigned LOW_BITS = (NCH - 1) * WIDTH;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;

  // Slot tracking, channel steering and frame snapshot; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      out         <= '0;
      out_valid   <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      slot        <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      out_valid   <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          // Start of frame always lands in channel 0; mid-frame it aborts the frame.
          out[0 +: WIDTH] <= in;
          out_valid       <= 16'd1;
          slot            <= SLOT_W'(1);
          state           <= LOCKED;
          locked          <= 1'b1;
          if (state == LOCKED && slot != '0) begin
            sync_err <= 1'b1;
          end
        end else if (state == LOCKED) begin
          // The counter free-runs on accepted samples; a missing marker is tolerated.
          out[slot*WIDTH +: WIDTH] <= in;
          out_valid                <= 16'd1 << slot;
          slot                     <= SLOT_W'(slot + SLOT_W'(1));
          if (slot == SLOT_W'(NCH - 1)) begin
            // The snapshot must include the channel 15 value arriving right now.
            frame_out   <= {in, out[0 +: LOW_BITS]};
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
